bcd_divider_seq: RTL and testbench

//  Multi-cycle divider for BCD operands, the inverse counterpart of the BCD multiplier datapath.
//  - Accepts dividend and divisor as packed BCD.
//  - Converts both to binary, then runs a restoring divide (1 quotient bit/cycle).
//  - Re-encodes quotient and remainder to BCD with a sequential double-dabble.
//  - Feeds the board's seven-segment display path; start/done handshake.

---
 rtl/bcd_div_pkg.sv | 25 ++
 rtl/bcd_divider_seq_dabble_adj.sv | 24 ++
 rtl/bcd_divider_seq_seg.sv | 30 +++
 rtl/bcd_divider_seq.sv | 198 +++++++++++++++++++
 tb/tb_bcd_divider_seq.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_div_pkg.sv
// Shared definitions for the sequential BCD divider.
//   state_t        : FSM state encoding (IDLE, LOAD, DIVIDE, ENCODE, DONE)
//   bw_of()        : binary working width for a given BCD digit count
//   BCD_MAX_NIBBLE : largest legal BCD digit value
//   DABBLE_THRESH  : double-dabble correction threshold
//   DABBLE_ADD     : double-dabble correction addend
package bcd_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DIVIDE = 3'd2,
    ST_ENCODE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int BCD_MAX_NIBBLE = 9;
  localparam int DABBLE_THRESH  = 5;
  localparam int DABBLE_ADD     = 3;

  function automatic int bw_of(input int digits);
    return 4 * digits;
  endfunction

endpackage

// File: rtl/bcd_divider_seq_dabble_adj.sv
// dabble_adj: combinational double-dabble correction. Every 4-bit nibble of
// din that is >= DABBLE_THRESH gets DABBLE_ADD added; other nibbles pass.
//   W    : vector width, a multiple of 4
//   din  : BCD digits before the shift of a dabble step
//   dout : corrected digits, ready to be shifted left by one
module dabble_adj
  import bcd_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din;
    for (int k = 0; k < W / 4; k++) begin
      if (din[4*k +: 4] >= 4'(DABBLE_THRESH)) begin
        dout[4*k +: 4] = din[4*k +: 4] + 4'(DABBLE_ADD);
      end
    end
  end

endmodule

// File: rtl/bcd_divider_seq_seg.sv
// bcd_seg7: one BCD digit to a seven-segment glyph, active-high, bit order
// {g,f,e,d,c,b,a}. Non-decimal codes blank the digit.
//   bcd : input digit
//   seg : segment drive
// Only present when SEG_DISPLAY_EN is defined.
`ifdef SEG_DISPLAY_EN
module bcd_seg7 (
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (bcd)
      4'd0: seg = 7'h3f;
      4'd1: seg = 7'h06;
      4'd2: seg = 7'h5b;
      4'd3: seg = 7'h4f;
      4'd4: seg = 7'h66;
      4'd5: seg = 7'h6d;
      4'd6: seg = 7'h7d;
      4'd7: seg = 7'h07;
      4'd8: seg = 7'h7f;
      4'd9: seg = 7'h6f;
      default: seg = 7'h00;
    endcase
  end

endmodule
`endif

// File: rtl/bcd_divider_seq.sv
// bcd_divider_seq: multi-cycle packed-BCD divider.
// Flow: LOAD converts the captured BCD operands to binary (1 cycle), DIVIDE
// runs a restoring divide (BW cycles, MSB first), ENCODE converts quotient
// and remainder back to BCD with a sequential double-dabble (BW cycles),
// DONE pulses done for one cycle. Invalid digits or a zero divisor skip
// straight from LOAD to DONE with zero results and a flag.
// Handshake: start is only sampled in IDLE or DONE; when sampled high the
// operands are captured and results/flags cleared on that same edge. While
// busy is high start is ignored. done is a single-cycle pulse and results
// stay stable from done until the next accepted start.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   start               : operation request
//   dividend, divisor   : packed BCD operands, digit 0 in [3:0]
//   busy, done          : status / completion pulse
//   quotient, remainder : packed BCD results
//   div_by_zero, bcd_err: result flags (bcd_err wins over div_by_zero)
//   dbg_state           : current FSM state
//   q_seg, r_seg        : seven-segment glyphs, only with SEG_DISPLAY_EN
// Macro: SEG_DISPLAY_EN adds the q_seg/r_seg outputs.
module bcd_divider_seq
  import bcd_div_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   dividend,
  input  logic [4*DIGITS-1:0]   divisor,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   quotient,
  output logic [4*DIGITS-1:0]   remainder,
  output logic                  div_by_zero,
  output logic                  bcd_err,
  output logic [2:0]            dbg_state
`ifdef SEG_DISPLAY_EN
  ,
  output logic [7*DIGITS-1:0]   q_seg,
  output logic [7*DIGITS-1:0]   r_seg
`endif
);

  localparam int BW = bw_of(DIGITS);
  localparam int CW = $clog2(BW + 1);

  state_t        state, state_next;
  logic          accept;
  logic [BW-1:0] dvd_bcd, dvs_bcd;   // captured operands
  logic [BW-1:0] dvs_bin;            // binary divisor
  logic [BW-1:0] dq;                 // dividend in, quotient out; then encode source
  logic [BW:0]   pr;                 // partial remainder; low bits are encode source
  logic [BW-1:0] q_bcd, r_bcd;       // double-dabble accumulators
  logic [CW-1:0] cnt;
  logic          last_step;

  logic [BW-1:0] dvd_conv, dvs_conv, pw;
  logic          nib_err;
  logic [BW:0]   shifted, trial;
  logic          no_borrow;
  logic [BW-1:0] q_adj, r_adj;
  logic          unused_bits;

  // BCD -> binary as sum of digit * 10^k; also flag any nibble above 9.
  always_comb begin
    dvd_conv = '0;
    dvs_conv = '0;
    nib_err  = 1'b0;
    pw       = BW'(1);
    for (int k = 0; k < DIGITS; k++) begin
      dvd_conv = dvd_conv + BW'(dvd_bcd[4*k +: 4]) * pw;
      dvs_conv = dvs_conv + BW'(dvs_bcd[4*k +: 4]) * pw;
      if (dvd_bcd[4*k +: 4] > 4'(BCD_MAX_NIBBLE) ||
          dvs_bcd[4*k +: 4] > 4'(BCD_MAX_NIBBLE)) begin
        nib_err = 1'b1;
      end
      pw = pw * BW'(10);
    end
  end

  // Restoring divide step: bring in the next dividend bit, keep the
  // difference only when it did not borrow.
  assign shifted   = {pr[BW-1:0], dq[BW-1]};
  assign trial     = shifted - {1'b0, dvs_bin};
  assign no_borrow = ~trial[BW];
  assign last_step = (cnt == CW'(BW - 1));

  dabble_adj #(.W(BW)) u_adj_q (.din(q_bcd), .dout(q_adj));
  dabble_adj #(.W(BW)) u_adj_r (.din(r_bcd), .dout(r_adj));

  // Top adjusted bit is shifted out each step; pr[BW] is only a borrow guard.
  assign unused_bits = ^{q_adj[BW-1], r_adj[BW-1], pr[BW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (nib_err || dvs_conv == '0) state_next = ST_DONE;
        else                           state_next = ST_DIVIDE;
      end
      ST_DIVIDE: if (last_step) state_next = ST_ENCODE;
      ST_ENCODE: if (last_step) state_next = ST_DONE;
      ST_DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy      = (state == ST_LOAD) || (state == ST_DIVIDE) || (state == ST_ENCODE);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_bcd     <= '0;
      dvs_bcd     <= '0;
      dvs_bin     <= '0;
      dq          <= '0;
      pr          <= '0;
      q_bcd       <= '0;
      r_bcd       <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      bcd_err     <= 1'b0;
    end else begin
      if (accept) begin
        dvd_bcd     <= dividend;
        dvs_bcd     <= divisor;
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
        bcd_err     <= 1'b0;
      end
      case (state)
        ST_LOAD: begin
          dvs_bin     <= dvs_conv;
          dq          <= dvd_conv;
          pr          <= '0;
          q_bcd       <= '0;
          r_bcd       <= '0;
          cnt         <= '0;
          bcd_err     <= nib_err;
          div_by_zero <= !nib_err && (dvs_conv == '0);
        end
        ST_DIVIDE: begin
          pr  <= no_borrow ? trial : shifted;
          dq  <= {dq[BW-2:0], no_borrow};
          cnt <= last_step ? '0 : cnt + CW'(1);
        end
        ST_ENCODE: begin
          // Quotient and remainder binaries shift MSB-first into the
          // corrected BCD accumulators.
          q_bcd <= {q_adj[BW-2:0], dq[BW-1]};
          r_bcd <= {r_adj[BW-2:0], pr[BW-1]};
          dq    <= {dq[BW-2:0], 1'b0};
          pr    <= {1'b0, pr[BW-2:0], 1'b0};
          cnt   <= last_step ? '0 : cnt + CW'(1);
          if (last_step) begin
            quotient  <= {q_adj[BW-2:0], dq[BW-1]};
            remainder <= {r_adj[BW-2:0], pr[BW-1]};
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEG_DISPLAY_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    bcd_seg7 u_q_seg (.bcd(quotient[4*g +: 4]),  .seg(q_seg[7*g +: 7]));
    bcd_seg7 u_r_seg (.bcd(remainder[4*g +: 4]), .seg(r_seg[7*g +: 7]));
  end
`else
  // No display path in this build.
`endif

endmodule

// File: tb/tb_bcd_divider_seq.sv
// Testbench for bcd_divider_seq (DIGITS=2): table-driven vectors plus
// hand-written sequences for start-while-busy, mid-operation reset and
// back-to-back starts. Expected results go into exp_q when start is driven
// and are popped when done is seen.
module tb_bcd_divider_seq;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;
  localparam int EW     = 2 * W + 2;   // {quotient, remainder, div_by_zero, bcd_err}

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  dividend = '0;
  logic [W-1:0]  divisor = '0;
  logic          busy, done, div_by_zero, bcd_err;
  logic [W-1:0]  quotient, remainder;
  logic [2:0]    dbg_state;
`ifdef SEG_DISPLAY_EN
  logic [7*DIGITS-1:0] q_seg, r_seg;
`endif

  bcd_divider_seq #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .bcd_err(bcd_err),
    .dbg_state(dbg_state)
`ifdef SEG_DISPLAY_EN
    , .q_seg(q_seg), .r_seg(r_seg)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  logic [EW-1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] o;
    int t;
    o = '0;
    t = v;
    for (int k = 0; k < DIGITS; k++) begin
      o[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return o;
  endfunction

  // Reference result using integer division on the decoded operands.
  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int av, bv, pwr;
    logic err;
    av = 0; bv = 0; pwr = 1; err = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) err = 1'b1;
      av = av + int'(a[4*k +: 4]) * pwr;
      bv = bv + int'(b[4*k +: 4]) * pwr;
      pwr = pwr * 10;
    end
    if (err)     return {{W{1'b0}}, {W{1'b0}}, 1'b0, 1'b1};
    if (bv == 0) return {{W{1'b0}}, {W{1'b0}}, 1'b1, 1'b0};
    return {to_bcd(av / bv), to_bcd(av % bv), 1'b0, 1'b0};
  endfunction

  // ---------------- driver tasks ----------------
  // Drives start for exactly one sampling edge (t0) and returns just after it.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [EW-1:0] exp);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done. elapsed = edges already past t0. Latency reported is the
  // index of the edge (relative to t0) at which done is first sampled high.
  task automatic wait_done(input string tag, input int exp_lat, input int elapsed,
                           output logic [EW-1:0] got);
    int cnt;
    bit seen;
    cnt  = elapsed;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " cleared"}, 32'({quotient, remainder, div_by_zero, bcd_err}), 32'd0);
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      cnt++;
    end
    got = {quotient, remainder, div_by_zero, bcd_err};
    if (!seen) begin
      checks++;
      fails++;
      $display("FAIL %s timeout: no done within 40 cycles, expected latency %0d", tag, exp_lat);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      check({tag, " latency"}, 32'(cnt + 1), 32'(exp_lat));
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL %s scoreboard: done with empty expected queue, got 0x%0h", tag, got);
      end else begin
        check({tag, " result"}, 32'(got), 32'(exp_q.pop_front()));
      end
    end
  endtask

  function automatic logic [EW-1:0] pack(input vec_t v);
    return {v.q, v.r, v.dbz, v.err};
  endfunction

  // ---------------- test ----------------
  initial begin
    logic [EW-1:0] got;
    logic [W-1:0]  ra, rb;
    int            done_cnt;

    vecs[0]  = '{8'h99, 8'h07, 8'h14, 8'h01, 1'b0, 1'b0, 18};
    vecs[1]  = '{8'h42, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 2};
    vecs[2]  = '{8'h05, 8'h09, 8'h00, 8'h05, 1'b0, 1'b0, 18};
    vecs[3]  = '{8'h99, 8'h01, 8'h99, 8'h00, 1'b0, 1'b0, 18};
    vecs[4]  = '{8'h3a, 8'h02, 8'h00, 8'h00, 1'b0, 1'b1, 2};
    vecs[5]  = '{8'h00, 8'h05, 8'h00, 8'h00, 1'b0, 1'b0, 18};
    vecs[6]  = '{8'ha0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 2};
    vecs[7]  = '{8'h99, 8'h99, 8'h01, 8'h00, 1'b0, 1'b0, 18};
    vecs[8]  = '{8'h50, 8'h07, 8'h07, 8'h01, 1'b0, 1'b0, 18};
    vecs[9]  = '{8'h12, 8'h3b, 8'h00, 8'h00, 1'b0, 1'b1, 2};
    vecs[10] = '{8'h98, 8'h10, 8'h09, 8'h08, 1'b0, 1'b0, 18};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({busy, done, quotient, remainder, div_by_zero, bcd_err}), 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      start_op(vecs[i].dvd, vecs[i].dvs, pack(vecs[i]));
      wait_done($sformatf("vec%0d", i), vecs[i].lat, 0, got);
`ifdef SEG_DISPLAY_EN
      if (vecs[i].q == 8'h14) check("q_seg 14", 32'(q_seg), 32'h366);
`endif
      @(negedge clk);
      check($sformatf("vec%0d done_pulse", i), 32'(done), 32'd0);
      check($sformatf("vec%0d held", i), 32'({quotient, remainder, div_by_zero, bcd_err}), 32'(pack(vecs[i])));
    end

    // Random valid operands against the model
    for (int i = 0; i < 8; i++) begin
      ra = to_bcd($urandom_range(0, 99));
      rb = to_bcd($urandom_range(1, 99));
      start_op(ra, rb, model(ra, rb));
      wait_done($sformatf("rnd%0d", i), 18, 0, got);
    end

    // start re-pulsed while busy with different operands: ignored
    start_op(8'h84, 8'h05, model(8'h84, 8'h05));
    repeat (4) @(posedge clk);
    @(negedge clk);
    dividend = 8'h99;
    divisor  = 8'h07;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("repulse", 18, 5, got);
    check("repulse q", 32'(quotient), 32'h16);
    check("repulse r", 32'(remainder), 32'h04);
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("repulse single_done", 32'(done_cnt), 32'd0);

    // Reset mid-operation aborts without done
    start_op(8'h84, 8'h05, model(8'h84, 8'h05));
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort outputs", 32'({busy, done, quotient, remainder, div_by_zero, bcd_err}), 32'd0);
    check("abort state", 32'(dbg_state), 32'd0);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort no_done", 32'(done_cnt), 32'd0);
    start_op(8'h50, 8'h07, {8'h07, 8'h01, 2'b00});
    wait_done("post_reset", 18, 0, got);

    // Back-to-back: start held in the DONE cycle, next op starts without IDLE
    start_op(8'h99, 8'h07, {8'h14, 8'h01, 2'b00});
    wait_done("b2b_first", 18, 0, got);
    dividend = 8'h84;
    divisor  = 8'h05;
    start    = 1'b1;
    exp_q.push_back({8'h16, 8'h04, 2'b00});
    @(posedge clk);
    #1 start = 1'b0;
    wait_done("b2b_second", 18, 0, got);

    check("queue drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
